// File: rtl/chesstypes.sv
// Shared chess types plus the direction tables and a direction search helper
// used by the ray-walking attack scanners.
package chesstypes;

  typedef enum logic {WHITE = 1'b0, BLACK = 1'b1} color_t;

  typedef enum logic [2:0] {EMPTY, PAWN, KNIGHT, BISHOP, ROOK, QUEEN, KING} piece_t;

  typedef struct packed {
    piece_t piece;
    color_t color;
  } fullpiece_t;

  // Even directions are orthogonal, odd directions are diagonal.
  typedef enum logic [2:0] {DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW} dir_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} scan_state_t;

  localparam logic signed [3:0] DIR_DROW [8] = '{4'sd1, 4'sd1, 4'sd0, -4'sd1, -4'sd1, -4'sd1, 4'sd0, 4'sd1};
  localparam logic signed [3:0] DIR_DCOL [8] = '{4'sd0, 4'sd1, 4'sd1, 4'sd1, 4'sd0, -4'sd1, -4'sd1, -4'sd1};

  // Lowest enabled direction at or above 'from'; bit 3 flags that one exists.
  function automatic logic [3:0] find_dir(logic [1:0] mode, logic [3:0] from);
    logic [3:0] r;
    r = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      if ((4'(i) >= from) && (((i % 2) == 1) ? mode[1] : mode[0])) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/sliding_attack_scanner_if.sv
// Request/result bundle between a requester and the sliding attack scanner.
interface sliding_attack_scanner_if;
  import chesstypes::*;

  // start is a single-cycle request honoured only while busy=0; field,
  // attacker and mode are sampled on that edge. board must stay stable
  // while busy=1. done pulses for one cycle with attacked/attacker_field
  // valid, and those hold until the next accepted start.
  logic             start;
  logic [5:0]       field;
  color_t           attacker;
  logic [1:0]       mode;
  fullpiece_t [63:0] board;
  logic             busy;
  logic             done;
  logic             attacked;
  logic [5:0]       attacker_field;
  scan_state_t      dbg_state;

  modport master (
    output start, field, attacker, mode, board,
    input  busy, done, attacked, attacker_field, dbg_state
  );

  modport slave (
    input  start, field, attacker, mode, board,
    output busy, done, attacked, attacker_field, dbg_state
  );

endinterface

// File: rtl/sliding_attack_scanner_ray_step.sv
// Combinational square stepper: square k steps from field along direction d,
// with an off-board flag.
module ray_step
  import chesstypes::*;
(
  input  logic [5:0] field_i,
  input  dir_t       d_i,
  input  logic [2:0] k_i,
  output logic [5:0] sq_o,
  output logic       offboard_o
);

  logic signed [3:0] row_s, col_s, k_s, row_n, col_n;

  // Deltas are only -1/0/+1, so add/subtract k instead of multiplying.
  // Any 4-bit signed overflow past 7 wraps negative and reads as off-board.
  always_comb begin
    row_s = signed'({1'b0, field_i[5:3]});
    col_s = signed'({1'b0, field_i[2:0]});
    k_s   = signed'({1'b0, k_i});
    if (DIR_DROW[d_i] > 4'sd0)      row_n = row_s + k_s;
    else if (DIR_DROW[d_i] < 4'sd0) row_n = row_s - k_s;
    else                            row_n = row_s;
    if (DIR_DCOL[d_i] > 4'sd0)      col_n = col_s + k_s;
    else if (DIR_DCOL[d_i] < 4'sd0) col_n = col_s - k_s;
    else                            col_n = col_s;
    offboard_o = row_n[3] | col_n[3];
    sq_o       = {row_n[2:0], col_n[2:0]};
  end

endmodule

// File: rtl/sliding_attack_scanner.sv
// Multi-cycle sliding attack detector: walks the enabled rays from a target
// square one square per clock and reports the first attacker found.
module sliding_attack_scanner
  import chesstypes::*;
#(
  parameter int MAX_RANGE    = 7,
  parameter bit INCLUDE_KING = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  sliding_attack_scanner_if.slave bus
);

  localparam logic [2:0] K_MAX = 3'(MAX_RANGE);

  scan_state_t state_q;
  logic [5:0]  field_q;
  color_t      attacker_q;
  logic [1:0]  mode_q;
  dir_t        d_q;
  logic [2:0]  k_q;
  logic        busy_q, done_q, attacked_q;
  logic [5:0]  attacker_field_q;

  logic [5:0]  sq_idx;
  logic        offboard;
  fullpiece_t  sq_piece;
  logic        piece_match, hit, empty_sq;
  logic [3:0]  first_dir, next_dir;

  ray_step u_ray_step (
    .field_i    (field_q),
    .d_i        (d_q),
    .k_i        (k_q),
    .sq_o       (sq_idx),
    .offboard_o (offboard)
  );

  always_comb begin
    sq_piece = bus.board[sq_idx];
    if (d_q[0]) piece_match = (sq_piece.piece == BISHOP) || (sq_piece.piece == QUEEN);
    else        piece_match = (sq_piece.piece == ROOK)   || (sq_piece.piece == QUEEN);
    if (INCLUDE_KING && (k_q == 3'd1) && (sq_piece.piece == KING)) piece_match = 1'b1;
    empty_sq  = !offboard && (sq_piece.piece == EMPTY);
    hit       = !offboard && (sq_piece.piece != EMPTY) && (sq_piece.color == attacker_q) && piece_match;
    first_dir = find_dir(bus.mode, 4'd0);
    next_dir  = find_dir(mode_q, {1'b0, d_q} + 4'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      field_q          <= 6'd0;
      attacker_q       <= WHITE;
      mode_q           <= 2'b00;
      d_q              <= DIR_N;
      k_q              <= 3'd1;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      attacked_q       <= 1'b0;
      attacker_field_q <= 6'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            field_q          <= bus.field;
            attacker_q       <= bus.attacker;
            mode_q           <= bus.mode;
            attacked_q       <= 1'b0;
            attacker_field_q <= 6'd0;
            busy_q           <= 1'b1;
            k_q              <= 3'd1;
            if (first_dir[3]) begin
              d_q     <= dir_t'(first_dir[2:0]);
              state_q <= ST_SCAN;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (hit) begin
            attacked_q       <= 1'b1;
            attacker_field_q <= sq_idx;
            state_q          <= ST_DONE;
            done_q           <= 1'b1;
          end else if (empty_sq && (k_q != K_MAX)) begin
            k_q <= k_q + 3'd1;
          end else if (next_dir[3]) begin
            // Off-board, blocked, or range exhausted: move to the next ray.
            d_q <= dir_t'(next_dir[2:0]);
            k_q <= 3'd1;
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          d_q     <= DIR_N;
          k_q     <= 3'd1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.attacked       = attacked_q;
  assign bus.attacker_field = attacker_field_q;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_sliding_attack_scanner.sv
// Bench for sliding_attack_scanner: a full-range instance and an
// adjacency-only instance, checked against a square-walking reference model.
module tb_sliding_attack_scanner;
  import chesstypes::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sliding_attack_scanner_if bus0 ();
  sliding_attack_scanner_if bus1 ();

  fullpiece_t [63:0] board_tb;
  assign bus0.board = board_tb;
  assign bus1.board = board_tb;

  sliding_attack_scanner #(.MAX_RANGE(7), .INCLUDE_KING(1'b1)) u_full (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  sliding_attack_scanner #(.MAX_RANGE(1), .INCLUDE_KING(1'b0)) u_adj (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic fullpiece_t fp(piece_t p, color_t c);
    fullpiece_t r;
    r.piece = p;
    r.color = c;
    return r;
  endfunction

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board_tb[i] = fp(EMPTY, WHITE);
  endtask

  // Reference: walk each enabled ray square by square with integer rows/cols.
  // Returns {attacked, attacker_field, latency}.
  function automatic logic [14:0] model(int maxr, bit ik, int f, color_t a, logic [1:0] m);
    int drow[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
    int dcol[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int n, af, r, c;
    bit found, stop, en, orth;
    fullpiece_t p;
    n = 0; af = 0; found = 0;
    for (int d = 0; d < 8 && !found; d++) begin
      orth = ((d % 2) == 0);
      en = orth ? m[0] : m[1];
      if (!en) continue;
      stop = 0;
      for (int k = 1; k <= maxr && !stop; k++) begin
        r = f / 8 + k * drow[d];
        c = f % 8 + k * dcol[d];
        n++;
        if (r < 0 || r > 7 || c < 0 || c > 7) begin
          stop = 1;
        end else begin
          p = board_tb[r * 8 + c];
          if (p.piece != EMPTY) begin
            stop = 1;
            if (p.color == a &&
                ((orth && (p.piece == ROOK || p.piece == QUEEN)) ||
                 (!orth && (p.piece == BISHOP || p.piece == QUEEN)) ||
                 (ik && k == 1 && p.piece == KING))) begin
              found = 1;
              af = r * 8 + c;
            end
          end
        end
      end
    end
    return {found, 6'(af), 8'(n + 1)};
  endfunction

  task automatic drive(int w, logic v, logic [5:0] f, color_t a, logic [1:0] m);
    if (w == 0) begin
      bus0.start = v; bus0.field = f; bus0.attacker = a; bus0.mode = m;
    end else begin
      bus1.start = v; bus1.field = f; bus1.attacker = a; bus1.mode = m;
    end
  endtask

  // {busy, done, attacked, attacker_field}
  function automatic logic [8:0] outs(int w);
    if (w == 0) return {bus0.busy, bus0.done, bus0.attacked, bus0.attacker_field};
    return {bus1.busy, bus1.done, bus1.attacked, bus1.attacker_field};
  endfunction

  // One request; poke>0 pulses a conflicting start at that cycle of the scan.
  task automatic run_scan(string tag, int w, logic [5:0] f, color_t a, logic [1:0] m, int poke);
    logic [8:0]  o;
    logic [14:0] e;
    int          cyc;
    exp_q.push_back(model((w == 0) ? 7 : 1, (w == 0), int'(f), a, m));
    @(negedge clk);
    drive(w, 1'b1, f, a, m);
    @(negedge clk);
    drive(w, 1'b0, f, a, m);
    cyc = 1;
    o = outs(w);
    check({tag, " busy"}, 32'(o[8]), 32'd1);
    while (!o[7] && cyc < 60) begin
      if (cyc == poke) drive(w, 1'b1, ~f, (a == WHITE) ? BLACK : WHITE, 2'b11);
      @(negedge clk);
      drive(w, 1'b0, f, a, m);
      cyc++;
      o = outs(w);
    end
    e = exp_q.pop_front();
    check({tag, " latency"}, 32'(cyc), 32'(e[7:0]));
    check({tag, " attacked"}, 32'(o[6]), 32'(e[14]));
    check({tag, " attacker_field"}, 32'(o[5:0]), 32'(e[13:8]));
    @(negedge clk);
    o = outs(w);
    check({tag, " done_pulse"}, 32'(o[8:7]), 32'd0);
    check({tag, " result_hold"}, 32'(o[6:0]), 32'({e[14], e[13:8]}));
  endtask

  initial begin
    logic [8:0] o;
    drive(0, 1'b0, 6'd0, WHITE, 2'b00);
    drive(1, 1'b0, 6'd0, WHITE, 2'b00);
    clear_board();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outs0", 32'(outs(0)), 32'd0);
    check("reset outs1", 32'(outs(1)), 32'd0);
    check("reset state", 32'(bus0.dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset outs0", 32'(outs(0)), 32'd0);

    board_tb[56] = fp(ROOK, WHITE);
    run_scan("rook_n", 0, 6'd0, WHITE, 2'b01, 0);
    board_tb[24] = fp(PAWN, BLACK);
    run_scan("rook_blocked", 0, 6'd0, WHITE, 2'b01, 0);

    clear_board();
    board_tb[54] = fp(BISHOP, BLACK);
    run_scan("bishop_diag", 0, 6'd27, BLACK, 2'b10, 0);
    run_scan("bishop_orth", 0, 6'd27, BLACK, 2'b01, 0);

    clear_board();
    board_tb[36] = fp(KING, WHITE);
    run_scan("king_adj", 0, 6'd27, WHITE, 2'b11, 0);
    board_tb[36] = fp(EMPTY, WHITE);
    board_tb[45] = fp(KING, WHITE);
    run_scan("king_far", 0, 6'd27, WHITE, 2'b11, 0);

    clear_board();
    board_tb[29] = fp(ROOK, WHITE);
    run_scan("range1_far", 1, 6'd27, WHITE, 2'b01, 0);
    board_tb[29] = fp(EMPTY, WHITE);
    board_tb[28] = fp(ROOK, WHITE);
    run_scan("range1_adj", 1, 6'd27, WHITE, 2'b01, 0);

    run_scan("mode0", 0, 6'd27, WHITE, 2'b00, 0);

    clear_board();
    board_tb[56] = fp(ROOK, WHITE);
    run_scan("start_busy", 0, 6'd0, WHITE, 2'b01, 3);

    // Reset in the middle of a scan: outputs drop and no done follows.
    @(negedge clk);
    drive(0, 1'b1, 6'd0, WHITE, 2'b01);
    @(negedge clk);
    drive(0, 1'b0, 6'd0, WHITE, 2'b01);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset outs", 32'(outs(0)), 32'd0);
    check("midreset state", 32'(bus0.dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      o = outs(0);
      check("midreset no_done", 32'(o[8:7]), 32'd0);
    end

    for (int it = 0; it < 30; it++) begin
      clear_board();
      for (int p = 0; p < int'($urandom_range(1, 8)); p++)
        board_tb[$urandom_range(0, 63)] = fp(piece_t'(3'($urandom_range(1, 6))), color_t'(1'($urandom_range(0, 1))));
      run_scan("rand_full", 0, 6'($urandom_range(0, 63)), color_t'(1'($urandom_range(0, 1))),
               2'($urandom_range(0, 3)), 0);
      run_scan("rand_adj", 1, 6'($urandom_range(0, 63)), color_t'(1'($urandom_range(0, 1))),
               2'($urandom_range(0, 3)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sliding_attack_scanner.md
# sliding_attack_scanner

Multi-cycle attack detector for the move-legality path. It walks the eight rays out from a target field, one square per clock, over a stable board snapshot. It reports whether a sliding attacker of a given colour hits the field, and from which square. It is a parametrised successor of the single-lookup piece-on-field checks, and covers rook, bishop and queen attacks plus optional king adjacency, with configurable ray range.

## Interface
Parameters:
- MAX_RANGE, default 7: maximum ray length in squares (1..7). A value of 1 gives adjacency-only scanning.
- INCLUDE_KING, default 1: when 1, a KING of the attacker colour at distance 1 counts as an attacker on any enabled ray.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous and active-low
- start  in  1  request pulse; accepted only in IDLE
- field  in  6  target square, row = field[5:3], col = field[2:0]; sampled on accept
- attacker  in  color_t  colour whose attack is searched; sampled on accept
- mode  in  2  bit0 enables orthogonal rays, bit1 enables diagonal rays; sampled on accept
- board  in  fullpiece_t [63:0]  board snapshot; must be held stable while busy=1
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse when the result is valid
- attacked  out  1  result flag; held until the next accept
- attacker_field  out  6  square of the first attacker found; 0 when attacked=0

## Operation
- FSM states and transitions:
  - IDLE: on start, latch field, attacker and mode. Select the lowest enabled direction and set k=1. Go to SCAN. If no direction is enabled (mode=0), go straight to DONE instead.
  - SCAN: each cycle evaluates exactly one (direction d, step k) pair. Outcomes:
    - Off-board square: advance to the next enabled direction.
    - EMPTY square: if k==MAX_RANGE, advance direction; otherwise k++.
    - Occupied square that is a hit: set attacked=1, attacker_field=square, go to DONE.
    - Any other occupied square: it blocks the ray; advance direction.
    - When no enabled direction remains after an advance, go to DONE with attacked=0.
  - DONE: pulse done and return to IDLE.
- A square is a hit when its colour == attacker and one of these holds:
  - orthogonal ray and piece is ROOK or QUEEN;
  - diagonal ray and piece is BISHOP or QUEEN;
  - INCLUDE_KING=1, k==1 and piece is KING.
- Direction order and deltas (drow, dcol): d0 N(+1,0), d1 NE(+1,+1), d2 E(0,+1), d3 SE(-1,+1), d4 S(-1,0), d5 SW(-1,-1), d6 W(0,-1), d7 NW(+1,-1). Even d is orthogonal, odd d is diagonal.
- Disabled directions are skipped combinationally and consume no cycle.
- Square arithmetic: row+k·drow and col+k·dcol are computed in 4-bit signed. The square is off-board if either result is <0 or >7. The index is row·8+col.
- start while busy=1 is ignored; no queueing.
- The first hit in direction order wins. attacker_field is deterministic.

## Timing
- Reset values: FSM=IDLE, busy=0, done=0, attacked=0, attacker_field=0, internal k=1, d=0.
- Accept on rising edge T. SCAN evaluations happen on edges T+1 .. T+N. done is high in the cycle following edge T+N. Latency is therefore N+1 cycles, where N is the number of evaluations (N=0 for mode=0 gives done after 1 cycle).
- Worst case: a queen scan from an empty central field with MAX_RANGE=7 takes 27 squares plus ray-terminating off-board evaluations. N ≤ 35 in all cases.
- attacked and attacker_field update on the DONE transition edge, are stable while done=1, and are cleared on the next accept.
- Reset asserted mid-scan: immediately return to reset values. No done pulse is produced for the aborted request.
- board is not registered. Changing it while busy=1 gives undefined results and is not checked.

## Structure
- chesstypes package holds:
  - color_t (WHITE, BLACK);
  - piece_t (EMPTY, PAWN, KNIGHT, BISHOP, ROOK, QUEEN, KING);
  - fullpiece_t {piece, color};
  - a new dir_t enum for the 8 directions;
  - constant arrays DIR_DROW/DIR_DCOL.
- Sub-module ray_step: combinational. Takes field, d and k; produces next square index and offboard flag. It is reusable by a later knight/pawn scanner.
- The FSM and hit logic stay in sliding_attack_scanner.

## Test plan
- Empty board except white ROOK at 56; field=0, attacker=WHITE, mode=01 → 7 evaluations, done 8 cycles after accept, attacked=1, attacker_field=56.
- Same, plus black PAWN at 24 → N blocked at k=3, E 7, S 1, W 1 evaluations (N=12). done at cycle 13, attacked=0, attacker_field=0.
- Black BISHOP at 54; field=27, attacker=BLACK, mode=10 → NE hit at k=3, done at cycle 4, attacked=1, attacker_field=54. With mode=01 instead → attacked=0.
- White KING at 36; field=27, mode=11, INCLUDE_KING=1 → N gives 5 evaluations, then NE hit, done at cycle 7, attacker_field=36. With the king moved to 45 → attacked=0.
- Instance with MAX_RANGE=1, white ROOK at 29, field=27, mode=01 → attacked=0. With the rook at 28 → attacked=1, attacker_field=28.
- Robustness:
  - start pulsed during busy → ignored, original result unchanged.
  - rst_n low at cycle 3 of a scan → all outputs 0 next cycle, no done pulse.
  - mode=00 → done at cycle 1, attacked=0.
